iob_vec_sum_master: RTL
=======================

# iob_vec_sum_master

IOb native initiator that reads a vector of packed signed 8-bit integers through the IOb-Cache front-end, sums every byte lane into an accumulator, and writes the 32-bit result back to a destination address. It is the requester side of the `iob_valid`/`iob_ready`/`iob_rvalid` front-end interface served by `memory_wrapper`. It sits between the accelerator control registers (start/length/addresses) and the cache.

## Interface
- ADDR_W, 32: IOb byte-address width.
- DATA_W, 32: IOb data width; fixed at 4 byte lanes.
- LEN_W, 16: width of the word-count input.
- ACC_W, 32: accumulator width; must be ≥ 10 and ≤ DATA_W.

- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start pulse; sampled only in IDLE.
- base_addr_i  in  ADDR_W  byte address of the first source word; bits [1:0] ignored.
- len_i  in  LEN_W  number of 32-bit source words.
- dst_addr_i  in  ADDR_W  byte address for the result write; bits [1:0] ignored.
- busy_o  out  1  high from the cycle after an accepted start until the result write is accepted.
- done_o  out  1  one-cycle pulse after the result write is accepted.
- sum_o  out  ACC_W  running sum; holds its final value until the next accepted start.
- iob_valid_o  out  1  request valid.
- iob_addr_o  out  ADDR_W  request byte address, word-aligned.
- iob_wdata_o  out  DATA_W  write data: sum_o sign-extended to DATA_W.
- iob_wstrb_o  out  DATA_W/8  4'hF on the result write, 0 on reads.
- iob_rdata_i  in  DATA_W  read data, valid when iob_rvalid_i is high.
- iob_rvalid_i  in  1  read response strobe.
- iob_ready_i  in  1  request accepted when iob_valid_o & iob_ready_i.

## Operation
- The FSM has five states: IDLE, RD_REQ, RD_WAIT, WR_REQ and DONE.
- **IDLE:**
  - On start_i, latch base, len and dst, and clear the accumulator and word counter.
  - Go to WR_REQ if len_i == 0; otherwise go to RD_REQ.
  - start_i in any other state is ignored.
- **RD_REQ:**
  - Drive iob_valid_o=1, iob_addr_o = base + 4·count, iob_wstrb_o=0.
  - Hold valid and address stable until iob_ready_i is high.
  - On acceptance, go to RD_WAIT. Only one transaction is outstanding at a time.
- **RD_WAIT:**
  - iob_valid_o=0.
  - On iob_rvalid_i, add the four sign-extended byte lanes of iob_rdata_i to the accumulator and increment count.
  - If count+1 == len, go to WR_REQ; otherwise go to RD_REQ.
- **WR_REQ:**
  - Drive iob_valid_o=1, iob_addr_o=dst, iob_wstrb_o=4'hF, iob_wdata_o = accumulator.
  - Hold until iob_ready_i is high, then go to DONE. No rvalid is expected for the write.
- **DONE:** done_o=1 for one cycle, then go to IDLE.
- **Arithmetic:**
  - Each lane is sign-extended to ACC_W.
  - The per-word sum (at most 10 bits signed) is added modulo 2^ACC_W, so there is no saturation.
  - Addresses wrap modulo 2^ADDR_W.
- **Boundary conditions:**
  - iob_rvalid_i outside RD_WAIT is ignored.
  - iob_ready_i while iob_valid_o=0 is ignored.
  - len = 2^LEN_W−1 is legal; the counter is LEN_W bits wide and must not wrap before completion.
- **Reset:**
  - rst_i in any state forces IDLE on that edge.
  - Any outstanding request is abandoned; a late rvalid is ignored per the rule above.
  - Reset values: iob_valid_o=0, iob_addr_o=0, iob_wdata_o=0, iob_wstrb_o=0, busy_o=0, done_o=0, sum_o=0.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from iob_ready_i or iob_rvalid_i to any output.
- Cycle 0 (start_i sampled in IDLE): RD_REQ is entered and iob_valid_o and busy_o are high in cycle 1.
- With ready always high and rvalid one cycle after acceptance, each word costs 2 cycles:
  - Requests are issued in cycles 1, 3, …, 2N−1.
  - rvalid arrives in cycles 2, 4, …, 2N.
  - WR_REQ is in cycle 2N+1 and done_o is high in cycle 2N+2.
  - busy_o falls in cycle 2N+2.
- With len=0: WR_REQ is in cycle 1 and done_o is high in cycle 2.
- Each cycle iob_ready_i stays low adds one cycle in RD_REQ or WR_REQ.
- Each extra cycle of rvalid latency adds one cycle in RD_WAIT.
- sum_o updates the cycle after each accepted rvalid.
- A new start is accepted no earlier than the cycle after done_o.

## Test plan
- **Basic sum:**
  - Stimulus: len=2, base=0x100; words 0x01020304 and 0xFFFFFFFF; ready=1; rvalid at +1.
  - Required: reads at 0x100 and 0x104; sum_o=6; write to dst with wdata=0x00000006 and wstrb=F; done_o in cycle 6.
- **Negative lanes:**
  - Stimulus: len=1, word 0x80808080.
  - Required: sum_o=−512 (0xFFFFFE00).
- **Zero length:** len=0 → no read is issued; write of 0 in cycle 1; done_o in cycle 2.
- **Back-pressure and latency:**
  - Stimulus: ready low for 3 cycles on each request; rvalid at +4.
  - Required: valid and address stay stable while stalled; final sum is correct; exactly len reads and one write are issued.
- **Start while busy and spurious strobes:**
  - Stimulus: start_i pulsed in RD_WAIT; rvalid asserted in IDLE.
  - Required: both are ignored; counters and sum are unchanged.
- **Reset mid-operation:**
  - Stimulus: rst_i in RD_WAIT of word 3 of 8, then a late rvalid.
  - Required: next cycle iob_valid_o=0, busy_o=0 and sum_o=0; the late rvalid is ignored; a following start with len=1 completes correctly.

Source files
------------

// File: rtl/iob_vec_sum_if.sv
// IOb native front-end bundle between a requester (master) and the cache wrapper (slave).
interface iob_vec_sum_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  valid;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic [DATA_W-1:0]     rdata;
   logic                  rvalid;
   logic                  ready;

   modport master (
      output valid, addr, wdata, wstrb,
      input  rdata, rvalid, ready
   );

   modport slave (
      input  valid, addr, wdata, wstrb,
      output rdata, rvalid, ready
   );
endinterface

// File: rtl/iob_vec_sum_master.sv
// IOb initiator: reads len words of packed signed bytes, sums every lane, writes the sum to dst.
//
// state   | meaning
// IDLE    | waiting for start_i
// RD_REQ  | read request on the bus, waiting for ready
// RD_WAIT | read accepted, waiting for rvalid
// WR_REQ  | result write on the bus, waiting for ready
// DONE    | one-cycle completion pulse
module iob_vec_sum_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16,
   parameter int ACC_W  = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [ADDR_W-1:0]   base_addr_i,
   input  logic [LEN_W-1:0]    len_i,
   input  logic [ADDR_W-1:0]   dst_addr_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [ACC_W-1:0]    sum_o,
   iob_vec_sum_if.master       iob
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_REQ  = 3'd1;
   localparam logic [2:0] S_RD_WAIT = 3'd2;
   localparam logic [2:0] S_WR_REQ  = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic signed [9:0] word_sum;
   logic              last_word;

   always_comb begin
      word_sum = '0;
      for (int i = 0; i < DATA_W/8; i++) begin
         word_sum = word_sum + 10'(signed'(iob.rdata[8*i +: 8]));
      end
   end

   // Compare one bit wider so len = 2^LEN_W-1 terminates without the counter wrapping.
   assign last_word = ({1'b0, cnt_q} + (LEN_W+1)'(1)) == {1'b0, len_q};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      dst_d   = dst_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               len_d = len_i;
               dst_d = dst_addr_i & ALIGN_MASK;
               acc_d = '0;
               cnt_d = '0;
               if (len_i == '0) begin
                  addr_d  = dst_addr_i & ALIGN_MASK;
                  state_d = S_WR_REQ;
               end else begin
                  addr_d  = base_addr_i & ALIGN_MASK;
                  state_d = S_RD_REQ;
               end
            end
         end
         S_RD_REQ: begin
            if (iob.ready) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (iob.rvalid) begin
               acc_d = acc_q + ACC_W'(word_sum);
               cnt_d = cnt_q + LEN_W'(1);
               if (last_word) begin
                  addr_d  = dst_q;
                  state_d = S_WR_REQ;
               end else begin
                  addr_d  = addr_q + ADDR_W'(4);
                  state_d = S_RD_REQ;
               end
            end
         end
         S_WR_REQ: begin
            if (iob.ready) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         dst_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         dst_q   <= dst_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   assign iob.valid = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
   assign iob.addr  = addr_q;
   assign iob.wdata = DATA_W'(signed'(acc_q));
   assign iob.wstrb = (state_q == S_WR_REQ) ? '1 : '0;
   assign busy_o    = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) || (state_q == S_WR_REQ);
   assign done_o    = (state_q == S_DONE);
   assign sum_o     = acc_q;

endmodule
